// File: rtl/regfile_sb.sv
// Two-read/one-write register file with same-cycle write bypass, async clear and a
// per-register busy scoreboard used by decode to detect RAW/WAW hazards.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              rsv_conflict,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;

  logic eff_we, eff_rsv;
  logic hit1, hit2;
  logic zero1, zero2;

  always_comb begin
    eff_we  = we3 && !(ZERO_REG && (wa3 == '0));
    eff_rsv = rsv_en && !(ZERO_REG && (rsv_addr == '0));
    hit1    = eff_we && (wa3 == ra1);
    hit2    = eff_we && (wa3 == ra2);
    zero1   = ZERO_REG && (ra1 == '0);
    zero2   = ZERO_REG && (ra2 == '0);
  end

  // Write clears first, then a reservation sets: the younger reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (eff_we) begin
      busy_d[wa3] = 1'b0;
    end
    if (eff_rsv) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        rf_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (eff_we) begin
        rf_q[wa3] <= wd3;
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    if (zero1) begin
      rd1 = '0;
    end else if (BYPASS && hit1) begin
      rd1 = wd3;
    end else begin
      rd1 = rf_q[ra1];
    end
  end

  always_comb begin
    if (zero2) begin
      rd2 = '0;
    end else if (BYPASS && hit2) begin
      rd2 = wd3;
    end else begin
      rd2 = rf_q[ra2];
    end
  end

  // A pending write landing this cycle satisfies the reader only when it is forwarded.
  always_comb begin
    busy1        = busy_q[ra1] && !(BYPASS && hit1) && !zero1;
    busy2        = busy_q[ra2] && !(BYPASS && hit2) && !zero2;
    rsv_conflict = rsv_en && busy_q[rsv_addr];
  end

  always_comb begin
    busy_cnt = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      busy_cnt = busy_cnt + {{ADDR_W{1'b0}}, busy_q[i]};
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios on a bypassing and a
// non-bypassing instance, then a randomised scoreboard run against a reference model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] ra1, ra2;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;

  logic [DW-1:0] rd1, rd2, rd1_nb, rd2_nb;
  logic          busy1, busy2, busy1_nb, busy2_nb;
  logic          rsv_conflict, rsv_conflict_nb;
  logic [AW:0]   busy_cnt, busy_cnt_nb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1),
    .busy2(busy2), .rsv_conflict(rsv_conflict), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_nb), .rd2(rd2_nb), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1_nb),
    .busy2(busy2_nb), .rsv_conflict(rsv_conflict_nb), .busy_cnt(busy_cnt_nb)
  );

  // Reference model of the bypassing, zero-register instance.
  logic [DW-1:0] m_rf   [32];
  logic          m_busy [32];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i]   <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (we3 && wa3 != 0) begin
        m_rf[wa3]   <= wd3;
        m_busy[wa3] <= 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] <= 1'b1;
    end
  end

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          b1;
    logic          b2;
    logic          conf;
    logic [AW:0]   cnt;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we3 && wa3 == a) return wd3;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return (a != 0) && m_busy[a] && !(we3 && wa3 == a);
  endfunction

  function automatic logic [AW:0] exp_cnt();
    logic [AW:0] c = '0;
    for (int i = 0; i < 32; i++) c = c + (m_busy[i] ? 1 : 0);
    return c;
  endfunction

  task automatic idle_inputs();
    we3 = 1'b0; wa3 = '0; wd3 = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF; rsv_en = 1'b1; rsv_addr = 5'd4;
    @(negedge clk);
    idle_inputs(); ra1 = 5'd5;
    #1;
    n_tests++;
    if (rd1 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL reset_pre_rd1: got %h want %h", rd1, 32'hDEADBEEF);
    end
    n_tests++;
    if (busy_cnt !== 6'd1) begin
      n_fail++; $display("FAIL reset_pre_cnt: got %0d want 1", busy_cnt);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (rd1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd1: got %h want 0", rd1);
    end
    n_tests++;
    if (busy_cnt !== 6'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h1234; rsv_en = 1'b1; rsv_addr = 5'd0; ra1 = 5'd0;
    #1;
    n_tests++;
    if (rd1 !== 32'h0) begin
      n_fail++; $display("FAIL zero_rd1: got %h want 0", rd1);
    end
    n_tests++;
    if (rsv_conflict !== 1'b0) begin
      n_fail++; $display("FAIL zero_conflict: got %b want 0", rsv_conflict);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy_cnt !== 6'd0) begin
      n_fail++; $display("FAIL zero_cnt: got %0d want 0", busy_cnt);
    end
    n_tests++;
    if (busy1 !== 1'b0 || rd1 !== 32'h0) begin
      n_fail++; $display("FAIL zero_after: got rd1=%h busy1=%b want 0/0", rd1, busy1);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_bypass();
    exp_t e;
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h11;
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h22; ra1 = 5'd7; ra2 = 5'd7;
    sb_q.push_back('{rd1: 32'h22, rd2: 32'h11, b1: 1'b0, b2: 1'b0, conf: 1'b0, cnt: '0});
    #1;
    e = sb_q.pop_front();
    n_tests++;
    if (rd1 !== e.rd1) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h want %h", rd1, e.rd1);
    end
    n_tests++;
    if (rd1_nb !== e.rd2) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got %h want %h", rd1_nb, e.rd2);
    end
    n_tests++;
    if (rd2 !== rd1) begin
      n_fail++; $display("FAIL bypass_port2_equal: got %h want %h", rd2, rd1);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rd1 !== 32'h22 || rd1_nb !== 32'h22) begin
      n_fail++; $display("FAIL bypass_after_edge: got %h/%h want 22/22", rd1, rd1_nb);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lifecycle();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd9; ra1 = 5'd9;
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (busy1 !== 1'b1 || busy_cnt !== 6'd1) begin
      n_fail++; $display("FAIL life_reserved: got busy1=%b cnt=%0d want 1/1", busy1, busy_cnt);
    end
    we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h55;
    #1;
    n_tests++;
    if (busy1 !== 1'b0 || rd1 !== 32'h55) begin
      n_fail++; $display("FAIL life_write_cycle: got busy1=%b rd1=%h want 0/55", busy1, rd1);
    end
    n_tests++;
    if (busy1_nb !== 1'b1) begin
      n_fail++; $display("FAIL life_nobypass_busy: got %b want 1", busy1_nb);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy_cnt !== 6'd0 || busy_cnt_nb !== 6'd0) begin
      n_fail++; $display("FAIL life_cleared: got %0d/%0d want 0/0", busy_cnt, busy_cnt_nb);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_simul();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h77; rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    n_tests++;
    if (rsv_conflict !== 1'b1) begin
      n_fail++; $display("FAIL simul_conflict: got %b want 1", rsv_conflict);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy_cnt !== 6'd1) begin
      n_fail++; $display("FAIL simul_cnt: got %0d want 1", busy_cnt);
    end
    @(negedge clk);
    idle_inputs(); ra1 = 5'd3; ra2 = 5'd3;
    #1;
    n_tests++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || rd1 !== 32'h77) begin
      n_fail++; $display("FAIL simul_busy: got b1=%b b2=%b rd1=%h want 1/1/77", busy1, busy2, rd1);
    end
    we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h78;
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (busy_cnt !== 6'd0) begin
      n_fail++; $display("FAIL simul_release: got %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_full();
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rsv_en = 1'b1; rsv_addr = 5'(i);
    end
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd1; ra1 = 5'd31; ra2 = 5'd31;
    #1;
    n_tests++;
    if (busy_cnt !== 6'd31 || rsv_conflict !== 1'b1) begin
      n_fail++; $display("FAIL full_cnt: got cnt=%0d conf=%b want 31/1", busy_cnt, rsv_conflict);
    end
    n_tests++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      n_fail++; $display("FAIL full_top_busy: got %b/%b want 1/1", busy1, busy2);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy_cnt !== 6'd31) begin
      n_fail++; $display("FAIL full_no_wrap: got %0d want 31", busy_cnt);
    end
    @(negedge clk);
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (busy_cnt !== 6'd0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL full_reset: got cnt=%0d busy1=%b want 0/0", busy_cnt, busy1);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    exp_t e;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we3      = ($urandom_range(0, 3) != 0);
      wa3      = 5'($urandom_range(0, 31));
      wd3      = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 31));
      ra1      = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
      ra2      = ($urandom_range(0, 5) == 0) ? ra1 : 5'($urandom_range(0, 31));
      sb_q.push_back('{rd1: exp_rd(ra1), rd2: exp_rd(ra2), b1: exp_busy(ra1),
                       b2: exp_busy(ra2), conf: rsv_en && m_busy[rsv_addr], cnt: exp_cnt()});
      #1;
      e = sb_q.pop_front();
      n_tests++;
      if (rd1 !== e.rd1 || rd2 !== e.rd2) begin
        n_fail++;
        $display("FAIL rand_rd[%0d]: got %h/%h want %h/%h", n, rd1, rd2, e.rd1, e.rd2);
      end
      n_tests++;
      if (busy1 !== e.b1 || busy2 !== e.b2 || rsv_conflict !== e.conf) begin
        n_fail++;
        $display("FAIL rand_busy[%0d]: got %b%b%b want %b%b%b", n, busy1, busy2, rsv_conflict,
                 e.b1, e.b2, e.conf);
      end
      n_tests++;
      if (busy_cnt !== e.cnt) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, busy_cnt, e.cnt);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    ra1 = '0; ra2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_zero_reg();
    test_bypass();
    test_lifecycle();
    test_simul();
    test_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
